serial_subtractor: RTL and testbench
====================================

Name: serial_subtractor

Overview:
- Bit-serial two's-complement subtractor. Computes Y = A + ~B + CI, one bit per clock, LSB first; CI=1 gives plain A - B.
- Produces carry (C) and signed-overflow (V) flags with the same meaning as the datapath's parallel adder.
- Sits beside the ALU adder as the reverse (subtract) path, for area-constrained sequencing.
- Uses a START/BUSY/DONE handshake towards the control FSM.

Parameters:
- WIDTH, 8, operand and result width in bits (≥2). The internal bit counter is clog2(WIDTH) bits wide.

Ports:
- CLK  input  1  system clock, all state updates on rising edge
- RST  input  1  asynchronous, active-high reset
- START  input  1  request; sampled only in IDLE or DONE
- A  input  WIDTH  minuend, captured on accepted START
- B  input  WIDTH  subtrahend, captured on accepted START
- CI  input  1  carry-in (1 = no borrow-in), captured on accepted START
- Y  output  WIDTH  result, A + ~B + CI mod 2^WIDTH
- C  output  1  carry out of MSB (1 = no borrow)
- V  output  1  signed overflow
- BUSY  output  1  high while bits are being processed
- DONE  output  1  high while Y/C/V hold a completed result

Behaviour:
- One clock, CLK. RST is asynchronous and active-high.
- Reset (asynchronous, takes effect immediately, any state):
  - state=IDLE, counter=0.
  - Y=0, C=0, V=0, BUSY=0, DONE=0.
  - The operand shift registers and the carry register are cleared.
- States:
  - IDLE: BUSY=0, DONE=0.
  - SHIFT: BUSY=1, DONE=0.
  - DONE: BUSY=0, DONE=1.
- IDLE or DONE with START=1 at edge k (accepted START):
  - Latch A, B (complemented), CI into the carry register.
  - counter=0, go to SHIFT.
  - DONE drops and Y/C/V clear to 0 at edge k.
- IDLE or DONE with START=0: hold state and all outputs.
- SHIFT, each edge:
  - sum = a0 ^ nb0 ^ c; c' = majority(a0, nb0, c).
  - Shift sum into the MSB of the Y register. Y shifts right, so after WIDTH edges bit 0 holds the first sum.
  - Shift the A and ~B registers right; counter += 1.
- Completion:
  - On the edge where counter == WIDTH-1 (edge k+WIDTH), the final bit is written.
  - C = final carry; V = (A[MSB] != B[MSB]) & (Y[MSB] != A[MSB]), using the captured operands.
  - Go to DONE.
- Latency: DONE=1 and results valid WIDTH cycles after the START edge (8 for the default).
- Y is not meaningful while BUSY=1; only DONE=1 qualifies it.
- START while in SHIFT: ignored, with no effect on the operation in flight.
- DONE is held, with results stable, until the next accepted START or RST. START may be held high continuously, giving back-to-back operations with one DONE cycle between them.
- A, B and CI changing after capture have no effect.
- RST asserted mid-SHIFT: aborts the operation immediately. After release the block is in IDLE and needs a fresh START.
- No wrap-around: the counter never exceeds WIDTH-1 and is reset to 0 on every accepted START.

Test Plan:
- Reset, then START with A=0x05, B=0x03, CI=1 → BUSY for 8 cycles; DONE at edge k+8 with Y=0x02, C=1, V=0.
- A=0x03, B=0x05, CI=1 → Y=0xFE, C=0, V=0.
- A=0x80, B=0x01, CI=1 → Y=0x7F, C=1, V=1. Then A=0x7F, B=0xFF, CI=1 → Y=0x80, C=0, V=1.
- A=0x10, B=0x01, CI=0 → Y=0x0E, C=1, V=0. DONE and results stay stable for 20 idle cycles.
- A=0x05, B=0x03, CI=1, then during SHIFT pulse START with A=0xFF, B=0x00 and also change A → result is still Y=0x02. Hold START high in DONE → new op starts, DONE low for 8 cycles.
- Assert RST at cycle 4 of SHIFT, between clock edges → all outputs 0 immediately. After release, IDLE persists with no DONE until START.

Source files
------------

// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor: Y = A + ~B + CI, one bit per clock, LSB first.
// Raises C/V like the parallel adder and uses a START/BUSY/DONE handshake.
//
//   state    | meaning
//   ---------+-----------------------------------------------
//   ST_IDLE  | no result held, waiting for START
//   ST_SHIFT | one result bit produced per clock
//   ST_DONE  | Y/C/V hold a completed result until next START
module serial_subtractor #(
   parameter int WIDTH = 8
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             START,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             CI,
   output logic [WIDTH-1:0] Y,
   output logic             C,
   output logic             V,
   output logic             BUSY,
   output logic             DONE
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

   state_t state, state_nxt;

   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] a_sr;
   logic [WIDTH-1:0] nb_sr;
   logic [WIDTH-1:0] y_sr;
   logic             carry;
   logic             c_reg;
   logic             v_reg;

   logic accept;
   logic last_bit;
   logic sum_bit;
   logic carry_nxt;
   logic ovf_bit;

   always_comb begin
      accept    = START && (state != ST_SHIFT);
      last_bit  = (cnt == CW'(WIDTH - 1));
      sum_bit   = a_sr[0] ^ nb_sr[0] ^ carry;
      carry_nxt = (a_sr[0] & nb_sr[0]) | (a_sr[0] & carry) | (nb_sr[0] & carry);
      // On the last bit, a_sr[0] is A's MSB and ~nb_sr[0] is B's MSB.
      ovf_bit   = (a_sr[0] ^ ~nb_sr[0]) & (sum_bit ^ a_sr[0]);
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      BUSY      = 1'b0;
      DONE      = 1'b0;
      case (state)
         ST_IDLE: begin
            if (START) state_nxt = ST_SHIFT;
         end
         ST_SHIFT: begin
            BUSY = 1'b1;
            if (last_bit) state_nxt = ST_DONE;
         end
         ST_DONE: begin
            DONE = 1'b1;
            if (START) state_nxt = ST_SHIFT;
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         cnt   <= '0;
         a_sr  <= '0;
         nb_sr <= '0;
         y_sr  <= '0;
         carry <= 1'b0;
         c_reg <= 1'b0;
         v_reg <= 1'b0;
      end else if (accept) begin
         cnt   <= '0;
         a_sr  <= A;
         nb_sr <= ~B;
         carry <= CI;
         y_sr  <= '0;
         c_reg <= 1'b0;
         v_reg <= 1'b0;
      end else if (state == ST_SHIFT) begin
         y_sr  <= {sum_bit, y_sr[WIDTH-1:1]};
         a_sr  <= {1'b0, a_sr[WIDTH-1:1]};
         nb_sr <= {1'b0, nb_sr[WIDTH-1:1]};
         carry <= carry_nxt;
         if (last_bit) begin
            c_reg <= carry_nxt;
            v_reg <= ovf_bit;
         end else begin
            cnt <= cnt + CW'(1);
         end
      end
   end

   assign Y = y_sr;
   assign C = c_reg;
   assign V = v_reg;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: fixed vector table, handshake corner
// sequences and randomized operands against an arithmetic reference model.
module tb_serial_subtractor;

   localparam int W = 8;

   logic         CLK;
   logic         RST;
   logic         START;
   logic [W-1:0] A;
   logic [W-1:0] B;
   logic         CI;
   logic [W-1:0] Y;
   logic         C;
   logic         V;
   logic         BUSY;
   logic         DONE;

   int n_checks = 0;
   int n_fail   = 0;

   serial_subtractor #(.WIDTH(W)) dut (
      .CLK   (CLK),
      .RST   (RST),
      .START (START),
      .A     (A),
      .B     (B),
      .CI    (CI),
      .Y     (Y),
      .C     (C),
      .V     (V),
      .BUSY  (BUSY),
      .DONE  (DONE)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic         ci;
      logic [W-1:0] y;
      logic         c;
      logic         v;
   } vec_t;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   // Reference: plain integer arithmetic on A + ~B + CI.
   function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci,
                                 output logic [W-1:0] y, output logic c, output logic v);
      logic [W:0]   u;
      logic [W-1:0] nb;
      int           s;
      nb = ~b;
      u  = {1'b0, a} + {1'b0, nb} + {{W{1'b0}}, ci};
      y  = u[W-1:0];
      c  = u[W];
      s  = int'($signed(a)) - int'($signed(b)) - 1 + int'(ci);
      v  = (s > (2 ** (W - 1)) - 1) || (s < -(2 ** (W - 1)));
   endfunction

   task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci);
      A = a; B = b; CI = ci; START = 1'b1;
      tick();
      START = 1'b0;
   endtask

   // Called one step after the START edge; counts edges until DONE.
   task automatic wait_done(output int lat);
      lat = 0;
      while (!DONE && lat < 4 * W) begin
         tick();
         lat++;
      end
   endtask

   task automatic run_and_check(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                                input logic ci, input logic [W-1:0] ey, input logic ec,
                                input logic ev);
      int lat;
      start_op(a, b, ci);
      check({tag, " busy_after_start"}, {31'd0, BUSY}, 32'd1);
      check({tag, " done_after_start"}, {31'd0, DONE}, 32'd0);
      check({tag, " cv_clear"}, {30'd0, C, V}, 32'd0);
      wait_done(lat);
      check({tag, " latency"}, lat, W);
      check({tag, " y"}, {24'd0, Y}, {24'd0, ey});
      check({tag, " c"}, {31'd0, C}, {31'd0, ec});
      check({tag, " v"}, {31'd0, V}, {31'd0, ev});
      check({tag, " busy_in_done"}, {31'd0, BUSY}, 32'd0);
   endtask

   vec_t vecs[5];

   initial begin
      logic [W-1:0] ry, ry2;
      logic         rc, rv, rc2, rv2;
      int           lat;

      vecs[0] = '{a: 8'h05, b: 8'h03, ci: 1'b1, y: 8'h02, c: 1'b1, v: 1'b0};
      vecs[1] = '{a: 8'h03, b: 8'h05, ci: 1'b1, y: 8'hFE, c: 1'b0, v: 1'b0};
      vecs[2] = '{a: 8'h80, b: 8'h01, ci: 1'b1, y: 8'h7F, c: 1'b1, v: 1'b1};
      vecs[3] = '{a: 8'h7F, b: 8'hFF, ci: 1'b1, y: 8'h80, c: 1'b0, v: 1'b1};
      vecs[4] = '{a: 8'h10, b: 8'h01, ci: 1'b0, y: 8'h0E, c: 1'b1, v: 1'b0};

      RST = 1'b1; START = 1'b0; A = '0; B = '0; CI = 1'b0;
      #2;
      check("reset_outputs", {21'd0, Y, C, V, BUSY, DONE}, 32'd0);
      tick(); tick();
      check("reset_held_outputs", {21'd0, Y, C, V, BUSY, DONE}, 32'd0);
      RST = 1'b0;
      tick(); tick();
      check("idle_no_start", {30'd0, BUSY, DONE}, 32'd0);

      foreach (vecs[i]) begin
         run_and_check($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].ci,
                       vecs[i].y, vecs[i].c, vecs[i].v);
      end

      // Result from vecs[4] must hold through idle cycles.
      for (int i = 0; i < 20; i++) tick();
      check("hold_done", {31'd0, DONE}, 32'd1);
      check("hold_y", {24'd0, Y}, 32'h0E);
      check("hold_cv", {30'd0, C, V}, 32'b10);

      // START and operand changes during SHIFT are ignored.
      start_op(8'h05, 8'h03, 1'b1);
      tick(); tick();
      A = 8'hFF; B = 8'h00; CI = 1'b0; START = 1'b1;
      tick();
      START = 1'b0; A = 8'hAA;
      lat = 3;
      while (!DONE && lat < 4 * W) begin
         tick();
         lat++;
      end
      check("ignore_start latency", lat, W);
      check("ignore_start y", {24'd0, Y}, 32'h02);
      check("ignore_start c", {31'd0, C}, 32'd1);

      // START held high in DONE: back-to-back ops with one DONE cycle between.
      A = 8'h03; B = 8'h05; CI = 1'b1; START = 1'b1;
      tick();
      check("b2b done_drop", {31'd0, DONE}, 32'd0);
      check("b2b busy", {31'd0, BUSY}, 32'd1);
      for (int i = 1; i < W; i++) begin
         tick();
         check($sformatf("b2b done_low_%0d", i), {31'd0, DONE}, 32'd0);
      end
      tick();
      check("b2b done_high", {31'd0, DONE}, 32'd1);
      check("b2b y", {24'd0, Y}, 32'hFE);
      A = 8'h80; B = 8'h01;
      tick();
      check("b2b restart", {30'd0, BUSY, DONE}, 32'b10);
      START = 1'b0;
      wait_done(lat);
      check("b2b second latency", lat, W);
      check("b2b second y", {24'd0, Y}, 32'h7F);
      check("b2b second v", {31'd0, V}, 32'd1);

      // Reset mid-SHIFT, between clock edges.
      start_op(8'h05, 8'h03, 1'b1);
      tick(); tick(); tick();
      #3;
      RST = 1'b1;
      #1;
      check("midshift_reset_outputs", {21'd0, Y, C, V, BUSY, DONE}, 32'd0);
      tick(); tick();
      RST = 1'b0;
      for (int i = 0; i < 12; i++) tick();
      check("after_reset_idle", {21'd0, Y, C, V, BUSY, DONE}, 32'd0);
      run_and_check("post_reset", 8'h05, 8'h03, 1'b1, 8'h02, 1'b1, 1'b0);

      // Randomized operands against the arithmetic model.
      for (int i = 0; i < 40; i++) begin
         logic [W-1:0] ra, rb;
         logic         rci;
         ra  = W'($urandom);
         rb  = W'($urandom);
         rci = 1'($urandom_range(0, 1));
         model(ra, rb, rci, ry, rc, rv);
         run_and_check($sformatf("rnd%0d", i), ra, rb, rci, ry, rc, rv);
         if ($urandom_range(0, 3) == 0) tick();
      end

      // Extremes through the model as well.
      model(8'h00, 8'h00, 1'b0, ry, rc, rv);
      run_and_check("edge_zero_ci0", 8'h00, 8'h00, 1'b0, ry, rc, rv);
      model(8'hFF, 8'h00, 1'b1, ry2, rc2, rv2);
      run_and_check("edge_ff_minus_0", 8'hFF, 8'h00, 1'b1, ry2, rc2, rv2);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
      $fatal(1, "watchdog");
   end

endmodule
